dmac_engine: RTL
================

DMAC_ENGINE -- requirements
Module: dmac_engine

Interface
REQ-001 Parameter: ADDR_STEP, default 4, byte increment applied to src/dest address per word transferred.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 op_start  input  1  one-cycle pulse from the register slave; starts draining the descriptor FIFO.
REQ-005 int_clear  input  1  clears interrupt.
REQ-006 fifo_rd_en  output  1  descriptor FIFO read request.
REQ-007 fifo_rd_ack / fifo_rd_err  input  1 each  FIFO read acknowledge / read-while-empty error, valid the cycle after fifo_rd_en.
REQ-008 fifo_src_addr, fifo_dest_addr, fifo_data_size  input  32 each  descriptor fields, valid with fifo_rd_ack.
REQ-009 m_req  output  1  bus request.
REQ-010 m_wr  output  1  1 = write, 0 = read.
REQ-011 m_addr  output  32  bus address.
REQ-012 m_dout  output  32  write data.
REQ-013 m_grant  input  1  bus grant; the transfer completes in any cycle with m_req=1 and m_grant=1.
REQ-014 m_din  input  32  read data, valid in the granted read cycle.
REQ-015 op_busy  output  1  high whenever the state is not IDLE.
REQ-016 interrupt  output  1  sticky completion flag.

Function
REQ-017 FSM states SHALL be IDLE, POP, LATCH, READ, WRITE, DONE.
REQ-018 IDLE: op_start=1 -> POP; otherwise stay in IDLE.
  - op_start outside IDLE SHALL be ignored.
REQ-019 POP: fifo_rd_en=1 for exactly one cycle -> LATCH.
REQ-020 LATCH transitions:
  - fifo_rd_ack=1: capture src, dest and size into internal registers; size!=0 -> READ; size==0 -> POP (descriptor skipped).
  - fifo_rd_err=1 (FIFO empty): -> DONE.
  - Neither asserted: -> DONE.
REQ-021 READ: m_req=1, m_wr=0, m_addr=src.
  - On m_grant: capture m_din into the data register -> WRITE.
  - No grant: hold all outputs unchanged.
REQ-022 WRITE: m_req=1, m_wr=1, m_addr=dest, m_dout=data register.
  - On m_grant: src+=ADDR_STEP, dest+=ADDR_STEP, size-=1.
  - If remaining size (before decrement) was 1 -> POP; else -> READ.
REQ-023 Address arithmetic SHALL be modulo 2^32, so 0xFFFFFFFC+4 = 0x00000000.
REQ-024 Size SHALL be an unsigned 32-bit word count and SHALL never underflow.
REQ-025 DONE: set interrupt=1 -> IDLE.
REQ-026 interrupt SHALL stay at 1 until int_clear=1.
  - int_clear in the same cycle as DONE: set wins.
REQ-027 m_req, fifo_rd_en, m_wr SHALL be 0 outside the states that drive them.
  - m_addr and m_dout SHALL be 0 in IDLE.
REQ-028 A word's write SHALL never be issued before its read completes.
  - Exactly one bus transaction SHALL be outstanding at a time.
REQ-029 Minimum latency per word SHALL be 2 cycles (READ + WRITE with immediate grant).
REQ-030 Descriptor overhead SHALL be 2 cycles (POP + LATCH).

Reset
REQ-031 reset=1 at a clock edge SHALL force the following, regardless of the state at that edge (including mid-transfer):
  - state = IDLE;
  - fifo_rd_en, m_req, m_wr, op_busy, interrupt = 0;
  - m_addr, m_dout and all internal address, size and data registers = 0.
REQ-032 An in-flight transfer aborted by reset SHALL NOT be resumed.

Structure
REQ-033 A shared package SHALL hold:
  - the state encoding;
  - ADDR_STEP default;
  - the 32-bit bus width constant.
REQ-034 The engine SHALL be one module with no sub-modules.
  - The next-state and datapath logic MAY be split into a separate combinational block within the same file.

Verification
REQ-035 Single descriptor:
  - Stimulus: src=0x100, dest=0x200, size=3, grant always 1, op_start pulse.
  - Response: reads at 0x100/0x104/0x108; writes at 0x200/0x204/0x208 carrying the read data; interrupt=1 after the FIFO-empty error; total 2+6+2+1 cycles.
REQ-036 Two descriptors, the second with size=0:
  - Response: second descriptor produces no bus traffic; a third POP then hits empty -> DONE.
REQ-037 Grant stalls:
  - Stimulus: m_grant held low for 5 cycles during READ and again during WRITE.
  - Response: m_req/m_addr/m_dout stable throughout each stall; data written equals data read.
REQ-038 Address wrap:
  - Stimulus: src=0xFFFFFFFC, size=2.
  - Response: second read at 0x00000000.
REQ-039 Reset mid-transfer:
  - Stimulus: reset=1 in WRITE.
  - Response: next cycle state IDLE, m_req=0, interrupt=0; a subsequent op_start with an empty FIFO gives interrupt=1.
REQ-040 Interrupt clear:
  - int_clear and DONE in the same cycle -> interrupt=1.
  - int_clear one cycle later -> interrupt=0.

Source files
------------

// File: rtl/dmac_engine_pkg.sv
// ============================================================================
//  Module      : dmac_engine_pkg
//  Description : Shared types and constants for the descriptor-driven DMA engine
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmac_engine_pkg;

  localparam int unsigned BUS_W         = 32;
  localparam int unsigned ADDR_STEP_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_LATCH = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

`default_nettype wire

// File: rtl/dmac_engine_if.sv
// ============================================================================
//  Module      : dmac_engine_if
//  Description : Control, descriptor-FIFO and bus-master signals of the engine
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmac_engine_if;
  import dmac_engine_pkg::*;

  logic             op_start;
  logic             int_clear;
  logic             op_busy;
  logic             interrupt;

  logic             fifo_rd_en;
  logic             fifo_rd_ack;
  logic             fifo_rd_err;
  logic [BUS_W-1:0] fifo_src_addr;
  logic [BUS_W-1:0] fifo_dest_addr;
  logic [BUS_W-1:0] fifo_data_size;

  logic             m_req;
  logic             m_wr;
  logic [BUS_W-1:0] m_addr;
  logic [BUS_W-1:0] m_dout;
  logic             m_grant;
  logic [BUS_W-1:0] m_din;

  modport master (
    input  op_start, int_clear,
    output op_busy, interrupt,
    output fifo_rd_en,
    input  fifo_rd_ack, fifo_rd_err, fifo_src_addr, fifo_dest_addr, fifo_data_size,
    output m_req, m_wr, m_addr, m_dout,
    input  m_grant, m_din
  );

  modport slave (
    output op_start, int_clear,
    input  op_busy, interrupt,
    input  fifo_rd_en,
    output fifo_rd_ack, fifo_rd_err, fifo_src_addr, fifo_dest_addr, fifo_data_size,
    input  m_req, m_wr, m_addr, m_dout,
    output m_grant, m_din
  );

endinterface

`default_nettype wire

// File: rtl/dmac_engine.sv
// ============================================================================
//  Module      : dmac_engine
//  Description : Drains a descriptor FIFO, copying each word src->dest over a
//                single-outstanding read/write bus master
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmac_engine
  import dmac_engine_pkg::*;
#(
  parameter int unsigned ADDR_STEP = ADDR_STEP_DEF
) (
  input  logic          clk,
  input  logic          reset,
  dmac_engine_if.master bus
);

  localparam logic [BUS_W-1:0] STEP = BUS_W'(ADDR_STEP);

  state_e           state_q, state_d;
  logic [BUS_W-1:0] src_q,   src_d;
  logic [BUS_W-1:0] dest_q,  dest_d;
  logic [BUS_W-1:0] size_q,  size_d;
  logic [BUS_W-1:0] data_q,  data_d;
  logic             irq_q,   irq_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dest_q  <= '0;
      size_q  <= '0;
      data_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dest_q  <= dest_d;
      size_q  <= size_d;
      data_q  <= data_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dest_d  = dest_q;
    size_d  = size_q;
    data_d  = data_q;

    unique case (state_q)
      ST_IDLE:  if (bus.op_start) state_d = ST_POP;
      ST_POP:   state_d = ST_LATCH;
      ST_LATCH: begin
        // A missing ack is treated like an empty FIFO so the engine can never stall here.
        if (bus.fifo_rd_ack) begin
          src_d   = bus.fifo_src_addr;
          dest_d  = bus.fifo_dest_addr;
          size_d  = bus.fifo_data_size;
          state_d = (bus.fifo_data_size == '0) ? ST_POP : ST_READ;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_READ: begin
        if (bus.m_grant) begin
          data_d  = bus.m_din;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (bus.m_grant) begin
          src_d   = src_q + STEP;
          dest_d  = dest_q + STEP;
          size_d  = (size_q != '0) ? size_q - 1'b1 : '0;
          state_d = (size_q <= BUS_W'(1)) ? ST_POP : ST_READ;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Completion set has priority over a simultaneous clear.
    if (state_q == ST_DONE)  irq_d = 1'b1;
    else if (bus.int_clear)  irq_d = 1'b0;
    else                     irq_d = irq_q;
  end

  assign bus.op_busy    = (state_q != ST_IDLE);
  assign bus.interrupt  = irq_q;
  assign bus.fifo_rd_en = (state_q == ST_POP);
  assign bus.m_req      = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign bus.m_wr       = (state_q == ST_WRITE);
  assign bus.m_addr     = (state_q == ST_READ)  ? src_q  :
                          (state_q == ST_WRITE) ? dest_q : '0;
  assign bus.m_dout     = (state_q == ST_WRITE) ? data_q : '0;

endmodule

`default_nettype wire
